// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I constants and the fetch entry type
package rv32i_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/rv32i_fetch_fifo.sv
// rtl/rv32i_fetch_fifo.sv - synchronous FIFO with flush, count, empty and full
module rv32i_fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  T                           i_data,
  input  logic                       i_pop,
  output T                           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T               r_mem [DEPTH];
  logic [AW-1:0]  r_rd_ptr;
  logic [AW-1:0]  r_wr_ptr;
  logic [CW-1:0]  r_count;
  logic           w_do_push;
  logic           w_do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = i_pop & (r_count != '0);
  assign w_do_push = i_push & ((r_count != CW'(DEPTH)) | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/rv32i_if_stage.sv
// rtl/rv32i_if_stage.sv - RV32I instruction fetch stage with in-order memory interface
module rv32i_if_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard_cnt;

  fetch_entry_t    w_fifo_head;
  fetch_entry_t    w_fifo_wdata;
  logic [CW-1:0]   w_fifo_count;
  logic            w_fifo_empty;
  logic            w_fifo_full;
  logic [XLEN-1:0] w_pcq_head;
  logic [CW-1:0]   w_pcq_count;
  logic            w_pcq_empty;
  logic            w_pcq_full;
  logic            w_pop;
  logic            w_issue;
  logic            w_req;
  logic            w_grant;
  logic            w_accept_rsp;
  logic            w_unused;

  assign o_if_valid = ~w_fifo_empty;
  assign w_pop      = o_if_valid & ~i_stall & ~i_redirect;

  // Requests in flight plus buffered entries never exceed the FIFO depth,
  // so every accepted response is guaranteed a free slot.
  assign w_issue = ((int'(r_outstanding) + int'(w_fifo_count)) < FIFO_DEPTH) | w_pop;
  assign w_req   = w_issue & ~i_redirect & ~i_rst;
  assign w_grant = w_req & i_imem_gnt;

  assign w_accept_rsp = i_imem_rvalid & (r_discard_cnt == '0);
  assign w_fifo_wdata = '{pc: w_pcq_head, instr: i_imem_rdata};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_discard_cnt <= '0;
    end else if (i_redirect) begin
      // Every request still in flight after this cycle belongs to the old path.
      r_fetch_pc    <= {i_redirect_pc[31:2], 2'b00};
      r_outstanding <= r_outstanding - CW'(i_imem_rvalid);
      r_discard_cnt <= r_outstanding - CW'(i_imem_rvalid);
    end else begin
      if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
      case ({w_grant, i_imem_rvalid})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
      if (i_imem_rvalid && r_discard_cnt != '0) r_discard_cnt <= r_discard_cnt - 1'b1;
    end
  end

  rv32i_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_fetch_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_redirect),
    .i_push  (w_accept_rsp),
    .i_data  (w_fifo_wdata),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  rv32i_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (logic [XLEN-1:0])
  ) u_pc_queue (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_redirect),
    .i_push  (w_grant),
    .i_data  (r_fetch_pc),
    .i_pop   (w_accept_rsp),
    .o_data  (w_pcq_head),
    .o_count (w_pcq_count),
    .o_empty (w_pcq_empty),
    .o_full  (w_pcq_full)
  );

  assign w_unused = &{1'b0, w_fifo_full, w_pcq_full, w_pcq_empty, w_pcq_count};

  assign o_imem_req  = w_req;
  assign o_imem_addr = r_fetch_pc;
  assign o_if_pc     = o_if_valid ? w_fifo_head.pc    : RESET_PC;
  assign o_if_instr  = o_if_valid ? w_fifo_head.instr : INSTR_NOP;

endmodule

// File: tb/tb_rv32i_if_stage.sv
// tb/tb_rv32i_if_stage.sv - self-checking bench for rv32i_if_stage
module tb_rv32i_if_stage;
  import rv32i_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        i_rst, i_imem_gnt, i_imem_rvalid, i_stall, i_redirect;
  logic [31:0] i_imem_rdata, i_redirect_pc;
  logic        o_imem_req, o_if_valid;
  logic [31:0] o_imem_addr, o_if_pc, o_if_instr;

  always #5 clk = ~clk;

  rv32i_if_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .i_stall(i_stall), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_if_valid(o_if_valid), .o_if_pc(o_if_pc), .o_if_instr(o_if_instr)
  );

  typedef struct { int due; logic [31:0] addr; int epoch; } mreq_t;
  mreq_t mq[$];

  int n_checks = 0, n_errors = 0;
  int cyc = 0, last_due = -1, epoch = 0, buffered = 0, n_pops = 0;
  int lat_min = 1, lat_max = 1;
  logic [31:0] exp_req_pc, exp_dec_pc;
  logic        s_req, s_valid, s_popped;
  logic [31:0] s_addr, s_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // One cycle: drive at the negedge, sample 1ns later, then advance the model to the next edge.
  task automatic cycle(input logic stall, input logic redir, input logic [31:0] rpc, input int gnt_pct);
    logic  rv, pop, exp_req;
    mreq_t e;
    int    due;
    i_stall       = stall;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_imem_gnt    = ($urandom_range(99) < gnt_pct);
    rv            = (mq.size() != 0) && (mq[0].due <= cyc);
    i_imem_rvalid = rv;
    i_imem_rdata  = rv ? mq[0].addr : $urandom;
    #1;
    s_req = o_imem_req; s_addr = o_imem_addr; s_valid = o_if_valid; s_pc = o_if_pc;
    check("if_valid", o_if_valid, buffered != 0);
    if (buffered == 0) check("if_instr_nop", o_if_instr, INSTR_NOP);
    pop = (buffered != 0) && !stall && !redir;
    s_popped = pop;
    if (pop) begin
      check("if_pc", o_if_pc, exp_dec_pc);
      check("if_instr", o_if_instr, exp_dec_pc);
    end
    exp_req = !redir && (((mq.size() + buffered) < DEPTH) || pop);
    check("imem_req", o_imem_req, exp_req);
    if (exp_req) check("imem_addr", o_imem_addr, exp_req_pc);
    if (rv) begin
      e = mq.pop_front();
      if (!redir && e.epoch == epoch) buffered++;
    end
    if (pop) begin
      buffered--;
      n_pops++;
      exp_dec_pc = exp_dec_pc + 32'd4;
    end
    if (o_imem_req && i_imem_gnt) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{due: due, addr: o_imem_addr, epoch: epoch});
      exp_req_pc = exp_req_pc + 32'd4;
    end
    if (redir) begin
      epoch++;
      buffered   = 0;
      exp_req_pc = {rpc[31:2], 2'b00};
      exp_dec_pc = {rpc[31:2], 2'b00};
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    i_rst = 1'b1; i_stall = 1'b0; i_redirect = 1'b0; i_imem_gnt = 1'b1;
    for (int k = 0; k < n; k++) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = $urandom;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      #1;
      check("rst_req", o_imem_req, 1'b0);
      check("rst_valid", o_if_valid, 1'b0);
      check("rst_pc", o_if_pc, RST_PC);
      check("rst_instr", o_if_instr, INSTR_NOP);
      check("rst_addr", o_imem_addr, RST_PC);
    end
    i_rst = 1'b0; i_imem_rvalid = 1'b0;
    mq.delete();
    last_due = -1; buffered = 0; epoch++;
    exp_req_pc = RST_PC; exp_dec_pc = RST_PC;
  endtask

  initial begin
    int  p0;
    logic found;
    i_rst = 1'b1; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
    i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    exp_req_pc = RST_PC; exp_dec_pc = RST_PC;
    @(negedge clk);

    // Streaming with 1-cycle memory: valid from cycle 2, one instruction per cycle.
    lat_min = 1; lat_max = 1;
    do_reset(2);
    p0 = n_pops;
    for (int c = 0; c < 12; c++) begin
      cycle(1'b0, 1'b0, '0, 100);
      if (c < 2)  check("t1_valid_early", s_valid, 1'b0);
      if (c == 2) check("t1_valid_c2", s_valid, 1'b1);
    end
    check("t1_throughput", n_pops - p0, 10);

    // Stall with head at 0x8.
    do_reset(1);
    for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0, '0, 100);
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, 1'b0, '0, 100);
      check("t2_head_pc", s_pc, 32'h8);
      check("t2_buffered_max", buffered <= DEPTH, 1'b1);
    end
    check("t2_req_dropped", s_req, 1'b0);
    for (int c = 0; c < 10; c++) cycle(1'b0, 1'b0, '0, 100);

    // Redirect to 0x103 with two requests outstanding.
    lat_min = 3; lat_max = 3;
    do_reset(1);
    cycle(1'b0, 1'b0, '0, 100);
    cycle(1'b0, 1'b0, '0, 100);
    cycle(1'b0, 1'b1, 32'h103, 100);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      cycle(1'b0, 1'b0, '0, 100);
      if (s_popped) begin
        found = 1'b1;
        check("t3_first_pc", s_pc, 32'h100);
      end
    end
    check("t3_pop_seen", found, 1'b1);

    // Redirect coinciding with a response while stalled.
    lat_min = 1; lat_max = 1;
    do_reset(1);
    cycle(1'b0, 1'b0, '0, 100);
    cycle(1'b0, 1'b0, '0, 100);
    cycle(1'b1, 1'b1, 32'h200, 100);
    cycle(1'b0, 1'b0, '0, 100);
    check("t4_valid_r1", s_valid, 1'b0);
    check("t4_req_r1", s_req, 1'b1);
    check("t4_addr_r1", s_addr, 32'h200);
    for (int c = 0; c < 5; c++) cycle(1'b0, 1'b0, '0, 100);

    // PC wrap at the top of the address space.
    do_reset(1);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 100);
    cycle(1'b0, 1'b0, '0, 100);
    check("t5_addr_top", s_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, '0, 100);
    check("t5_addr_wrap", s_addr, 32'h0000_0000);
    for (int c = 0; c < 5; c++) cycle(1'b0, 1'b0, '0, 100);

    // Reset with two requests outstanding.
    lat_min = 3; lat_max = 3;
    do_reset(1);
    cycle(1'b0, 1'b0, '0, 100);
    cycle(1'b0, 1'b0, '0, 100);
    do_reset(1);
    cycle(1'b0, 1'b0, '0, 100);
    check("t6_req_post_rst", s_req, 1'b1);
    check("t6_addr_post_rst", s_addr, RST_PC);
    for (int c = 0; c < 8; c++) cycle(1'b0, 1'b0, '0, 100);

    // Randomized traffic: variable latency, grant, stall, redirect and occasional reset.
    lat_min = 1; lat_max = 4;
    p0 = n_pops;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(999) < 2) do_reset(1);
      else cycle($urandom_range(99) < 25, $urandom_range(99) < 4, $urandom, 70);
    end
    check("rand_progress", (n_pops - p0) > 200, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
